mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one 64-bit-line memory port between the I-cache miss engine (read-only) and the D-cache miss/writeback engine (read and write).
- Sits between the two cache controllers and the unified memory.
- Arbitrates, sequences a fixed-latency memory access, and returns the line to the requester with a 4-phase req/done handshake.
- Keeps grant and conflict counters for performance analysis.

Parameters:
- WORD_SIZE, 16, address width.
- FETCH_SIZE, 64, line width (4 words).
- LATENCY, 4, memory cycles a command is held; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- i_req  in  1  I-cache line read request; held until i_done.
- i_addr  in  WORD_SIZE  I-cache line address.
- i_rdata  out  FETCH_SIZE  line returned to I-cache.
- i_done  out  1  I access complete, i_rdata valid.
- d_req_read  in  1  D-cache line read request.
- d_req_write  in  1  D-cache line writeback request.
- d_addr  in  WORD_SIZE  D-cache line address.
- d_wdata  in  FETCH_SIZE  writeback line.
- d_rdata  out  FETCH_SIZE  line returned to D-cache.
- d_done  out  1  D access complete.
- m_readM  out  1  memory read command.
- m_writeM  out  1  memory write command.
- m_addressM  out  WORD_SIZE  memory address.
- m_wdata  out  FETCH_SIZE  memory write data (unidirectional; tri-state resolution lives at top level).
- m_rdata  in  FETCH_SIZE  memory read data, valid in the last command cycle.
- i_grant_cnt  out  16  number of I grants.
- d_grant_cnt  out  16  number of D grants.
- conflict_cnt  out  16  arbitrations with both sides requesting.

Behaviour:
- Reset (reset_n low at an edge, including mid-access):
  - state=IDLE; m_readM=m_writeM=0; m_addressM=0; m_wdata=0.
  - i_rdata=d_rdata=0; i_done=d_done=0; all counters=0; last_grant=I.
  - Any access in flight is abandoned.
- States: IDLE, I_ACC, D_ACC, I_DONE, D_DONE. All outputs are registered.
- IDLE:
  - D request = d_req_read | d_req_write.
  - Only I requesting -> I_ACC.
  - Only D requesting -> D_ACC.
  - Both requesting -> D_ACC (fixed D priority), conflict_cnt+1.
  - Neither -> stay in IDLE.
- Entering an ACC state:
  - Latch address, direction and wdata.
  - Drive m_readM or m_writeM =1 with m_addressM/m_wdata from the latch.
  - cnt=LATENCY-1; increment the winner's grant counter; update last_grant.
- D with both read and write high: write is performed and counted as one grant.
- ACC:
  - Command held constant for exactly LATENCY cycles; cnt decrements each cycle.
  - In the cycle with cnt==0 and a read, m_rdata is captured into i_rdata/d_rdata at the edge.
  - Next state is x_DONE; commands drop to 0; m_addressM/m_wdata return to 0.
  - A write leaves d_rdata unchanged.
- x_DONE:
  - x_done=1, rdata held stable.
  - Stays until the requester's request (all request lines for D) is low, then -> IDLE with done=0.
  - The other side is not arbitrated while in DONE.
- Latency: request first seen in IDLE at cycle 0 -> command cycles 1..LATENCY -> done from cycle LATENCY+1.
- Request withdrawn mid-ACC: the access completes; DONE lasts exactly one cycle.
- Address/data changes during ACC are ignored because the latched copies are used.
- Counters wrap 16'hFFFF -> 0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on conflict the side that did NOT win the previous grant (last_grant) wins. After reset last_grant=I, so the first conflict goes to D; consecutive conflicts alternate D, I, D, ...
- Undefined: fixed D priority on every conflict; last_grant is still tracked but unused.
- Counters behave identically in both builds.

Test Plan:
- I read alone, LATENCY=4, i_addr=16'h0124, m_rdata=64'h0123_4567_89AB_CDEF in cycle 4 -> m_readM high cycles 1-4 with m_addressM=16'h0124; i_done from cycle 5 with i_rdata=64'h0123_4567_89AB_CDEF; i_done held until i_req drops; i_grant_cnt=1.
- D write, d_addr=16'h0040, d_wdata=64'hDEAD_BEEF_0000_1111 -> m_writeM high 4 cycles with that address/data; d_done cycle 5; d_rdata stays 0; d_grant_cnt=1.
- i_req and d_req_read rise together, macro off, repeated 3 times -> D served first each time, I served after D's handshake; conflict_cnt=3.
- Same stimulus, MEM_ARB_ROUND_ROBIN_EN defined, 4 conflicts -> winners D, I, D, I; conflict_cnt=4.
- reset_n low in cycle 2 of a D read -> next edge: m_readM=0, state IDLE, all counters 0, d_done never asserted; a new i_req afterwards completes normally.
- i_req dropped in cycle 2 of an I access -> command still held 4 cycles; i_done high exactly one cycle; a pending d_req_read is then granted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache miss engines onto one fixed-latency line memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate conflict winners instead of fixed D priority.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned FETCH_SIZE = 64,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [WORD_SIZE-1:0]  i_addr,
  output logic [FETCH_SIZE-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [WORD_SIZE-1:0]  d_addr,
  input  logic [FETCH_SIZE-1:0] d_wdata,
  output logic [FETCH_SIZE-1:0] d_rdata,
  output logic                  d_done,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [WORD_SIZE-1:0]  m_addressM,
  output logic [FETCH_SIZE-1:0] m_wdata,
  input  logic [FETCH_SIZE-1:0] m_rdata,
  output logic [15:0]           i_grant_cnt,
  output logic [15:0]           d_grant_cnt,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state, state_next;
  grant_t     last_grant;
  logic [3:0] cnt;
  logic       d_any, prefer_d, d_wins, acc_last;
  logic       grant_i, grant_d, conflict;

  always_comb begin
    d_any      = d_req_read | d_req_write;
    prefer_d   = (last_grant == GRANT_I);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    d_wins     = prefer_d;
`else
    // Fixed D priority; last_grant is still maintained for the round-robin build.
    d_wins     = prefer_d | 1'b1;
`endif
    acc_last   = (cnt == '0);
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    conflict   = 1'b0;
    case (state)
      IDLE: begin
        conflict = i_req & d_any;
        if (d_any && (!i_req || d_wins)) begin
          grant_d    = 1'b1;
          state_next = D_ACC;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = I_ACC;
        end
      end
      I_ACC:   if (acc_last) state_next = I_DONE;
      D_ACC:   if (acc_last) state_next = D_DONE;
      I_DONE:  if (!i_req)   state_next = IDLE;
      D_DONE:  if (!d_any)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_readM      <= 1'b0;
      m_writeM     <= 1'b0;
      m_addressM   <= '0;
      m_wdata      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      cnt          <= '0;
      last_grant   <= GRANT_I;
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      i_done <= (state_next == I_DONE);
      d_done <= (state_next == D_DONE);
      if (conflict) conflict_cnt <= conflict_cnt + 16'd1;
      if (grant_i) begin
        m_readM     <= 1'b1;
        m_writeM    <= 1'b0;
        m_addressM  <= i_addr;
        m_wdata     <= '0;
        cnt         <= CNT_INIT;
        i_grant_cnt <= i_grant_cnt + 16'd1;
        last_grant  <= GRANT_I;
      end
      // Write wins when both D request lines are high.
      if (grant_d) begin
        m_readM     <= ~d_req_write;
        m_writeM    <= d_req_write;
        m_addressM  <= d_addr;
        m_wdata     <= d_req_write ? d_wdata : '0;
        cnt         <= CNT_INIT;
        d_grant_cnt <= d_grant_cnt + 16'd1;
        last_grant  <= GRANT_D;
      end
      if (state == I_ACC || state == D_ACC) begin
        if (acc_last) begin
          m_readM    <= 1'b0;
          m_writeM   <= 1'b0;
          m_addressM <= '0;
          m_wdata    <= '0;
          if (m_readM) begin
            if (state == I_ACC) i_rdata <= m_rdata;
            else                d_rdata <= m_rdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: vector table of single accesses
// plus hand-written conflict, reset-abort and request-withdrawal sequences.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_done, d_req_read, d_req_write, d_done, m_readM, m_writeM;
  logic [15:0] i_addr, d_addr, m_addressM;
  logic [63:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
  logic [15:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(16), .FETCH_SIZE(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_addressM(m_addressM),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    bit          is_i;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem;
    bit          exp_wr;
    logic [63:0] exp_mwdata;
    logic [63:0] exp_irdata;
    logic [63:0] exp_drdata;
  } vec_t;

  vec_t        vecs[5];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] exp_ig, exp_dg, exp_cf;
  bit          last_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_i_grant_cnt"}, i_grant_cnt, exp_ig);
    chk({tag, "_d_grant_cnt"}, d_grant_cnt, exp_dg);
    chk({tag, "_conflict_cnt"}, conflict_cnt, exp_cf);
  endtask

  task automatic wait_done(input bit side_d, input string tag);
    int unsigned n = 0;
    while (!(side_d ? d_done : i_done) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_done_timeout"}, side_d ? d_done : i_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0124, 64'h0, 64'h0123_4567_89AB_CDEF,
                1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0040, 64'hDEAD_BEEF_0000_1111, 64'hAAAA_AAAA_AAAA_AAAA,
                1'b1, 64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0088, 64'h9999_9999_9999_9999, 64'h5555_6666_7777_8888,
                1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h5555_6666_7777_8888};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h00F0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0123_4567_89AB_CDEF, 64'h5555_6666_7777_8888};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 64'h0, 64'h8000_0000_0000_0001,
                1'b0, 64'h0, 64'h8000_0000_0000_0001, 64'h5555_6666_7777_8888};

    reset_n = 1'b0; i_req = 1'b0; d_req_read = 1'b0; d_req_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    exp_ig = '0; exp_dg = '0; exp_cf = '0; last_d = 1'b0;
    step();
    step();
    chk("rst_readM", m_readM, 0);
    chk("rst_writeM", m_writeM, 0);
    chk("rst_addr", m_addressM, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_done", {i_done, d_done}, 0);
    chk_counters("rst");
    reset_n = 1'b1;
    step();

    // Single accesses from the table
    for (int v = 0; v < 5; v++) begin
      vec_t t;
      t = vecs[v];
      i_addr = t.addr; d_addr = t.addr; d_wdata = t.wdata; m_rdata = ~t.mem;
      i_req = t.is_i; d_req_read = t.rd; d_req_write = t.wr;
      if (t.is_i) exp_ig++; else exp_dg++;
      for (int k = 1; k <= int'(LAT); k++) begin
        step();
        chk("vec_readM", m_readM, !t.exp_wr);
        chk("vec_writeM", m_writeM, t.exp_wr);
        chk("vec_addr", m_addressM, t.addr);
        chk("vec_wdata", m_wdata, t.exp_mwdata);
        if (k == 2) begin
          i_addr = ~t.addr; d_addr = ~t.addr; d_wdata = ~t.wdata;
        end
        if (k == int'(LAT)) m_rdata = t.mem;
      end
      step();
      chk("vec_done", t.is_i ? i_done : d_done, 1);
      chk("vec_other_done", t.is_i ? d_done : i_done, 0);
      chk("vec_i_rdata", i_rdata, t.exp_irdata);
      chk("vec_d_rdata", d_rdata, t.exp_drdata);
      chk("vec_cmd_drop", {m_readM, m_writeM}, 0);
      chk("vec_addr_zero", m_addressM, 0);
      m_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
      step();
      chk("vec_done_held", t.is_i ? i_done : d_done, 1);
      chk("vec_i_rdata_held", i_rdata, t.exp_irdata);
      chk("vec_d_rdata_held", d_rdata, t.exp_drdata);
      i_req = 1'b0; d_req_read = 1'b0; d_req_write = 1'b0;
      step();
      chk("vec_done_drop", {i_done, d_done}, 0);
      chk_counters("vec");
    end

    // Simultaneous I and D read requests
    begin
      int unsigned n_conf;
      bit serve_loser;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      n_conf = 4; serve_loser = 1'b0;
`else
      n_conf = 3; serve_loser = 1'b1;
`endif
      for (int unsigned n = 0; n < n_conf; n++) begin
        bit dw;
        logic [63:0] line;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        dw = !last_d;
`else
        dw = 1'b1;
`endif
        line = 64'hC0DE_0000_0000_0000 | 64'(n);
        i_addr = 16'(32'h1000 + n); d_addr = 16'(32'h2000 + n); m_rdata = line;
        i_req = 1'b1; d_req_read = 1'b1;
        exp_cf++;
        if (dw) exp_dg++; else exp_ig++;
        last_d = dw;
        step();
        chk("cf_readM", m_readM, 1);
        chk("cf_winner_addr", m_addressM, dw ? 16'(32'h2000 + n) : 16'(32'h1000 + n));
        wait_done(dw, "cf_winner");
        chk("cf_winner_rdata", dw ? d_rdata : i_rdata, line);
        if (dw) d_req_read = 1'b0; else i_req = 1'b0;
        if (!serve_loser) begin
          i_req = 1'b0; d_req_read = 1'b0;
        end
        step();
        chk("cf_winner_done_drop", dw ? d_done : i_done, 0);
        chk("cf_idle_readM", m_readM, 0);
        if (serve_loser) begin
          step();
          chk("cf_loser_readM", m_readM, 1);
          chk("cf_loser_addr", m_addressM, dw ? 16'(32'h1000 + n) : 16'(32'h2000 + n));
          if (dw) exp_ig++; else exp_dg++;
          last_d = !dw;
          wait_done(!dw, "cf_loser");
          chk("cf_loser_rdata", dw ? i_rdata : d_rdata, line);
          i_req = 1'b0; d_req_read = 1'b0;
          step();
          chk("cf_loser_done_drop", {i_done, d_done}, 0);
        end
      end
      chk_counters("cf");
    end

    // Reset in the middle of a D read abandons it
    d_addr = 16'h0300; d_req_read = 1'b1; m_rdata = 64'h3333_3333_3333_3333;
    step();
    chk("rsta_readM", m_readM, 1);
    step();
    reset_n = 1'b0;
    step();
    exp_ig = '0; exp_dg = '0; exp_cf = '0; last_d = 1'b0;
    chk("rsta_readM_off", m_readM, 0);
    chk("rsta_addr", m_addressM, 0);
    chk("rsta_d_done", d_done, 0);
    chk("rsta_rdata", {i_rdata, d_rdata} == '0, 1);
    chk_counters("rsta");
    reset_n = 1'b1; d_req_read = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rsta_d_done_quiet", {d_done, m_readM}, 0);
    end
    i_addr = 16'h0500; m_rdata = 64'h0BAD_F00D_1234_5678; i_req = 1'b1; exp_ig++;
    for (int k = 1; k <= int'(LAT); k++) begin
      step();
      chk("post_rst_readM", m_readM, 1);
    end
    step();
    chk("post_rst_i_done", i_done, 1);
    chk("post_rst_i_rdata", i_rdata, 64'h0BAD_F00D_1234_5678);
    i_req = 1'b0;
    step();
    chk("post_rst_done_drop", i_done, 0);
    chk_counters("post_rst");

    // I request withdrawn mid-access while D becomes pending
    i_addr = 16'h0777; m_rdata = 64'h0; i_req = 1'b1; exp_ig++;
    step();
    chk("wd_readM_c1", m_readM, 1);
    step();
    i_req = 1'b0; d_addr = 16'h0888; d_req_read = 1'b1;
    chk("wd_readM_c2", m_readM, 1);
    step();
    chk("wd_readM_c3", m_readM, 1);
    step();
    chk("wd_readM_c4", m_readM, 1);
    chk("wd_addr_c4", m_addressM, 16'h0777);
    m_rdata = 64'h7777_0000_1111_2222;
    step();
    chk("wd_i_done", i_done, 1);
    chk("wd_i_rdata", i_rdata, 64'h7777_0000_1111_2222);
    chk("wd_cmd_off", m_readM, 0);
    step();
    chk("wd_i_done_one_cycle", i_done, 0);
    chk("wd_idle_readM", m_readM, 0);
    step();
    exp_dg++;
    chk("wd_d_readM", m_readM, 1);
    chk("wd_d_addr", m_addressM, 16'h0888);
    wait_done(1'b1, "wd_d");
    chk("wd_d_rdata", d_rdata, 64'h7777_0000_1111_2222);
    d_req_read = 1'b0;
    step();
    chk("wd_d_done_drop", d_done, 0);
    chk_counters("wd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
